// File: rtl/mem_ctrl.sv
// Purpose: serialises 32-bit fetch / LSB requests onto a byte-wide RAM/IO port.
// Latency: N-byte read done at t0+N+2, N-byte write done at t0+N+1 (t0 = IDLE sample cycle).
// Backpressure: rdy=0 freezes everything; IO writes hold while UART buffer is full (MEMCTRL_IO_STALL_EN).
//
// Ports: clk/rst (async active-low)/rdy global control; jump_wrong flush;
//        mem_din/mem_dout/mem_a/mem_wr byte-wide RAM port; io_buffer_full UART status;
//        if_read_signal/if_addr/if_data/if_done fetch side;
//        lsb_read_signal/lsb_write_signal/requiring_length/mem_addr/to_mem_data/
//        from_mem_data/lsb_done load/store side.
// Build option: define MEMCTRL_IO_STALL_EN to stall IO-region stores on io_buffer_full.
module mem_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_read_signal,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        lsb_read_signal,
  input  logic        lsb_write_signal,
  input  logic [2:0]  requiring_length,
  input  logic [31:0] mem_addr,
  input  logic [31:0] to_mem_data,
  output logic [31:0] from_mem_data,
  output logic        lsb_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_READ,
    S_LSB_READ,
    S_LSB_WRITE,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] base_addr;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [31:0] cap_word;
  logic [31:0] cur_addr;
  logic [2:0]  len;
  logic [2:0]  cnt;
  logic [2:0]  req_len;
  logic        done_is_if;
  logic        io_stall;
  logic [7:0]  wbyte;

  assign cur_addr = base_addr + {29'd0, cnt};
  assign req_len  = requiring_length[2] ? 3'd4 : (requiring_length[1] ? 3'd2 : 3'd1);

  // Bit 0 of the length is implied by the other two bits.
  logic unused_len0;
  assign unused_len0 = requiring_length[0];

`ifdef MEMCTRL_IO_STALL_EN
  assign io_stall = (state == S_LSB_WRITE) && (cur_addr[17:16] == IO_SEL) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full ^ (cur_addr[17:16] == IO_SEL);
  assign io_stall  = 1'b0;
`endif

  always_comb begin
    wbyte = wdata[7:0];
    case (cnt[1:0])
      2'd1:    wbyte = wdata[15:8];
      2'd2:    wbyte = wdata[23:16];
      2'd3:    wbyte = wdata[31:24];
      default: wbyte = wdata[7:0];
    endcase
  end

  // Read data lags its address by one cycle, so with cnt addresses issued
  // the byte arriving now belongs to slot cnt-1.
  always_comb begin
    cap_word = rbuf;
    case (cnt)
      3'd1:    cap_word[7:0]   = mem_din;
      3'd2:    cap_word[15:8]  = mem_din;
      3'd3:    cap_word[23:16] = mem_din;
      3'd4:    cap_word[31:24] = mem_din;
      default: cap_word = rbuf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_a     = 32'd0;
    mem_wr    = 1'b0;
    mem_dout  = 8'd0;
    if_done   = 1'b0;
    lsb_done  = 1'b0;
    case (state)
      S_IDLE: begin
        // Writes are committed stores, so a flush never blocks them.
        if (lsb_write_signal) begin
          state_nxt = S_LSB_WRITE;
        end else if (!jump_wrong && lsb_read_signal) begin
          state_nxt = S_LSB_READ;
        end else if (!jump_wrong && if_read_signal) begin
          state_nxt = S_IF_READ;
        end
      end
      S_IF_READ, S_LSB_READ: begin
        if (cnt < len) begin
          mem_a = cur_addr;
        end
        if (jump_wrong) begin
          state_nxt = S_IDLE;
        end else if (cnt == len) begin
          state_nxt = S_DONE;
        end
      end
      S_LSB_WRITE: begin
        mem_a = cur_addr;
        if (!io_stall) begin
          mem_wr   = rdy;
          mem_dout = wbyte;
          if (cnt == len - 3'd1) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if_done   = done_is_if;
        lsb_done  = !done_is_if;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_addr     <= 32'd0;
      wdata         <= 32'd0;
      rbuf          <= 32'd0;
      len           <= 3'd0;
      cnt           <= 3'd0;
      done_is_if    <= 1'b0;
      if_data       <= 32'd0;
      from_mem_data <= 32'd0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (state_nxt != S_IDLE) begin
            cnt        <= 3'd0;
            rbuf       <= 32'd0;
            wdata      <= to_mem_data;
            done_is_if <= (state_nxt == S_IF_READ);
            if (state_nxt == S_IF_READ) begin
              base_addr <= if_addr;
              len       <= 3'd4;
            end else begin
              base_addr <= mem_addr;
              len       <= req_len;
            end
          end
        end
        S_IF_READ, S_LSB_READ: begin
          if (!jump_wrong) begin
            rbuf <= cap_word;
            cnt  <= cnt + 3'd1;
            if (cnt == len) begin
              if (state == S_IF_READ) begin
                if_data <= cap_word;
              end else begin
                from_mem_data <= cap_word;
              end
            end
          end
        end
        S_LSB_WRITE: begin
          if (!io_stall) begin
            cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  localparam int NOFF = 14;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_read_signal, if_done;
  logic [31:0] if_addr, if_data;
  logic        lsb_read_signal, lsb_write_signal, lsb_done;
  logic [2:0]  requiring_length;
  logic [31:0] mem_addr, to_mem_data, from_mem_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.IO_SEL(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_read_signal(if_read_signal), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .lsb_read_signal(lsb_read_signal), .lsb_write_signal(lsb_write_signal),
    .requiring_length(requiring_length), .mem_addr(mem_addr), .to_mem_data(to_mem_data),
    .from_mem_data(from_mem_data), .lsb_done(lsb_done)
  );

  // Byte-addressed RAM: sparse contents with a deterministic background pattern.
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Expected little-endian word of n bytes starting at addr, upper bytes zero.
  function automatic logic [31:0] exp_word(input logic [31:0] addr, input int n);
    logic [31:0] w = 32'd0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ram_byte(addr + 32'(k));
    return w;
  endfunction

  // The RAM advances together with the rest of the system: frozen while rdy=0.
  logic [31:0] a_s;
  logic        wr_s;
  logic [7:0]  d_s;
  always @(negedge clk) begin
    a_s  = mem_a;
    wr_s = mem_wr;
    d_s  = mem_dout;
  end
  always @(posedge clk) begin
    if (rdy && rst) begin
      if (wr_s === 1'b1) ram[a_s] = d_s;
      else mem_din <= ram_byte(a_s);
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-offset record of the last transaction (offset 0 = IDLE sample cycle).
  logic [31:0] oa [NOFF];
  logic        ow [NOFF];
  logic [7:0]  od [NOFF];
  int          done_off, n_done, n_other;
  logic [31:0] dat_done;

  // kind: 0 fetch, 1 load, 2 store.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [2:0] rl,
                         input logic [31:0] wd, input int jw_off, input int rdy_from,
                         input int rdy_n, input int full_n);
    done_off = -1; n_done = 0; n_other = 0; dat_done = 32'd0;
    for (int o = 0; o < NOFF; o++) begin
      jump_wrong     = (o == jw_off);
      rdy            = !(o >= rdy_from && o < rdy_from + rdy_n);
      io_buffer_full = (o >= 1 && o <= full_n);
      if (o == 0) begin
        case (kind)
          0: begin if_read_signal = 1'b1; if_addr = addr; end
          1: begin lsb_read_signal = 1'b1; mem_addr = addr; requiring_length = rl; end
          default: begin
            lsb_write_signal = 1'b1; mem_addr = addr; requiring_length = rl; to_mem_data = wd;
          end
        endcase
      end
      if ((done_off >= 0 && o == done_off + 1) || (jw_off >= 0 && kind != 2 && o == jw_off + 1)) begin
        if_read_signal = 1'b0; lsb_read_signal = 1'b0; lsb_write_signal = 1'b0;
      end
      @(negedge clk);
      oa[o] = mem_a; ow[o] = mem_wr; od[o] = mem_dout;
      if (((kind == 0) ? if_done : lsb_done) === 1'b1) begin
        n_done++;
        if (done_off < 0) begin
          done_off = o;
          dat_done = (kind == 0) ? if_data : from_mem_data;
        end
      end
      if (((kind == 0) ? lsb_done : if_done) === 1'b1) n_other++;
      tick();
    end
    if_read_signal = 1'b0; lsb_read_signal = 1'b0; lsb_write_signal = 1'b0;
    jump_wrong = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({mem_a, mem_wr, mem_dout, if_data, from_mem_data, if_done, lsb_done} !== 107'd0) begin
      failures++;
      $display("FAIL reset_in got mem_a=%h wr=%b dout=%h if_data=%h lsb_data=%h dn=%b%b exp all 0",
               mem_a, mem_wr, mem_dout, if_data, from_mem_data, if_done, lsb_done);
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({mem_a, mem_wr, mem_dout, if_done, lsb_done} !== 43'd0) begin
      failures++;
      $display("FAIL reset_idle got mem_a=%h wr=%b dout=%h exp 0", mem_a, mem_wr, mem_dout);
    end
    tick();
  endtask

  task automatic test_fetch();
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    run_txn(0, 32'h100, 3'd4, 32'd0, -1, -1, 0, 0);
    checks++;
    if (done_off !== 6) begin failures++; $display("FAIL fetch_done got=%0d exp=6", done_off); end
    checks++;
    if (dat_done !== 32'h00100513) begin
      failures++; $display("FAIL fetch_data got=%h exp=00100513", dat_done);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[1+k] !== 32'h100 + 32'(k) || ow[1+k] !== 1'b0) begin
        failures++; $display("FAIL fetch_addr%0d got=%h wr=%b exp=%h", k, oa[1+k], ow[1+k], 32'h100 + 32'(k));
      end
    end
    checks++;
    if (oa[6] !== 32'd0 || n_done !== 1 || n_other !== 0) begin
      failures++; $display("FAIL fetch_done_cycle got mem_a=%h dones=%0d other=%0d exp 0/1/0", oa[6], n_done, n_other);
    end
  endtask

  task automatic test_random_reads();
    for (int i = 0; i < 10; i++) begin
      int kind = (i == 0) ? 0 : int'($urandom_range(0, 1));
      int sel  = int'($urandom_range(0, 2));
      int n;
      int bad = 0;
      logic [2:0]  rl;
      logic [31:0] addr = (i == 0) ? 32'hFFFF_FFFE : $urandom;
      logic [31:0] ew;
      if (i == 1) addr = 32'hFFFF_FFFF;
      if (sel == 2)      begin n = 4; rl = 3'($urandom_range(4, 7)); end
      else if (sel == 1) begin n = 2; rl = 3'($urandom_range(2, 3)); end
      else               begin n = 1; rl = 3'd1; end
      if (kind == 0) n = 4;
      ew = exp_word(addr, n);
      run_txn(kind, addr, rl, 32'd0, -1, -1, 0, 0);
      for (int k = 0; k < n; k++) if (oa[1+k] !== addr + 32'(k) || ow[1+k] !== 1'b0) bad++;
      checks++;
      if (done_off !== n + 2 || n_done !== 1) begin
        failures++; $display("FAIL rread%0d_done got=%0d/%0d exp=%0d/1", i, done_off, n_done, n + 2);
      end
      checks++;
      if (dat_done !== ew || bad != 0) begin
        failures++; $display("FAIL rread%0d_data got=%h badaddr=%0d exp=%h", i, dat_done, bad, ew);
      end
    end
  endtask

  task automatic test_priority();
    int lsb_off = -1, if_off = -1;
    logic [31:0] lsb_dat = 32'd0, if_dat = 32'd0, a1 = 32'd0, a6 = 32'd0;
    logic [31:0] ew;
    ram[32'h2000] = 8'hFF; ram[32'h2001] = 8'h80;
    ew = exp_word(32'h500, 4);
    if_read_signal = 1'b1; if_addr = 32'h500;
    lsb_read_signal = 1'b1; mem_addr = 32'h2000; requiring_length = 3'b010;
    for (int o = 0; o < 16; o++) begin
      if (lsb_off >= 0 && o == lsb_off + 1) lsb_read_signal = 1'b0;
      if (if_off >= 0 && o == if_off + 1) if_read_signal = 1'b0;
      @(negedge clk);
      if (o == 1) a1 = mem_a;
      if (o == 6) a6 = mem_a;
      if (lsb_done === 1'b1 && lsb_off < 0) begin lsb_off = o; lsb_dat = from_mem_data; end
      if (if_done === 1'b1 && if_off < 0) begin if_off = o; if_dat = if_data; end
      tick();
    end
    if_read_signal = 1'b0; lsb_read_signal = 1'b0;
    checks++;
    if (lsb_off !== 4 || lsb_dat !== 32'h000080FF || a1 !== 32'h2000) begin
      failures++; $display("FAIL prio_lsb got off=%0d data=%h a=%h exp 4/000080ff/2000", lsb_off, lsb_dat, a1);
    end
    checks++;
    if (if_off !== 11 || if_dat !== ew || a6 !== 32'h500) begin
      failures++; $display("FAIL prio_fetch got off=%0d data=%h a=%h exp 11/%h/500", if_off, if_dat, a6, ew);
    end
  endtask

  task automatic test_store();
    int nw = 0, bad = 0;
    run_txn(2, 32'h3FFFE, 3'd4, 32'hDEADBEEF, -1, -1, 0, 0);
    for (int o = 0; o < NOFF; o++) begin
      if (ow[o] === 1'b1) begin
        if (o != 1 + nw || nw >= 4 || oa[o] !== 32'h3FFFE + 32'(nw) || od[o] !== 8'((32'hDEADBEEF >> (8*nw)))) bad++;
        nw++;
      end
    end
    checks++;
    if (nw != 4 || bad != 0) begin failures++; $display("FAIL store_bytes got writes=%0d bad=%0d exp 4/0", nw, bad); end
    checks++;
    if (done_off !== 5 || n_done !== 1 || n_other !== 0) begin
      failures++; $display("FAIL store_done got=%0d/%0d exp=5/1", done_off, n_done);
    end
    checks++;
    if (ow[5] !== 1'b0 || od[5] !== 8'd0 || oa[5] !== 32'd0) begin
      failures++; $display("FAIL store_idle_bus got wr=%b dout=%h a=%h exp 0", ow[5], od[5], oa[5]);
    end
    for (int i = 0; i < 6; i++) begin
      int sel = int'($urandom_range(0, 2));
      int n = (sel == 2) ? 4 : (sel == 1) ? 2 : 1;
      logic [2:0]  rl = (sel == 2) ? 3'd4 : (sel == 1) ? 3'd2 : 3'd1;
      logic [31:0] addr = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8*n)) - 32'd1;
      addr[17:16] = 2'($urandom_range(0, 2));
      run_txn(2, addr, rl, wd, -1, -1, 0, 0);
      nw = 0;
      for (int o = 0; o < NOFF; o++) if (ow[o] === 1'b1) nw++;
      checks++;
      if (done_off !== n + 1 || nw != n) begin
        failures++; $display("FAIL rstore%0d got done=%0d writes=%0d exp %0d/%0d", i, done_off, nw, n + 1, n);
      end
      run_txn(1, addr, rl, 32'd0, -1, -1, 0, 0);
      checks++;
      if (dat_done !== (wd & mask)) begin
        failures++; $display("FAIL rstore%0d_readback got=%h exp=%h", i, dat_done, wd & mask);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev = if_data;
    int nw = 0;
    run_txn(0, 32'h700, 3'd4, 32'd0, 2, -1, 0, 0);
    @(negedge clk);
    checks++;
    if (n_done !== 0 || if_data !== prev) begin
      failures++; $display("FAIL flush_fetch got dones=%0d if_data=%h exp 0/%h", n_done, if_data, prev);
    end
    checks++;
    if (oa[3] !== 32'd0 || oa[4] !== 32'd0) begin
      failures++; $display("FAIL flush_idle got a3=%h a4=%h exp 0", oa[3], oa[4]);
    end
    tick();
    run_txn(2, 32'h1230, 3'd4, 32'hA5A5_1234, 2, -1, 0, 0);
    for (int o = 0; o < NOFF; o++) if (ow[o] === 1'b1) nw++;
    checks++;
    if (done_off !== 5 || nw != 4) begin
      failures++; $display("FAIL flush_store got done=%0d writes=%0d exp 5/4", done_off, nw);
    end
    run_txn(2, 32'h1240, 3'd1, 32'h0000_00C3, 0, -1, 0, 0);
    checks++;
    if (done_off !== 2) begin failures++; $display("FAIL flush_idle_store got done=%0d exp=2", done_off); end
    jump_wrong = 1'b1; lsb_read_signal = 1'b1; if_read_signal = 1'b1;
    mem_addr = 32'h40; if_addr = 32'h80; requiring_length = 3'd1;
    tick();
    jump_wrong = 1'b0; lsb_read_signal = 1'b0; if_read_signal = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_a !== 32'd0) begin failures++; $display("FAIL flush_reject_read got mem_a=%h exp=0", mem_a); end
    tick(); tick();
  endtask

  task automatic test_rdy();
    logic [31:0] ew = exp_word(32'h800, 4);
    int nw = 0;
    run_txn(0, 32'h800, 3'd4, 32'd0, -1, 3, 2, 0);
    checks++;
    if (done_off !== 8 || dat_done !== ew) begin
      failures++; $display("FAIL rdy_fetch got done=%0d data=%h exp 8/%h", done_off, dat_done, ew);
    end
    run_txn(2, 32'h880, 3'd2, 32'h0000_BEEF, -1, 1, 1, 0);
    for (int o = 0; o < NOFF; o++) if (ow[o] === 1'b1) nw++;
    checks++;
    if (ow[1] !== 1'b0 || nw != 2 || done_off !== 4) begin
      failures++; $display("FAIL rdy_store got wr1=%b writes=%0d done=%0d exp 0/2/4", ow[1], nw, done_off);
    end
  endtask

  task automatic test_io_stall();
    int exp_w;
    int early = 0, nw = 0;
`ifdef MEMCTRL_IO_STALL_EN
    exp_w = 4;
`else
    exp_w = 1;
`endif
    run_txn(2, 32'h30000, 3'd1, 32'h0000_0041, -1, -1, 0, 3);
    for (int o = 0; o < NOFF; o++) begin
      if (ow[o] === 1'b1) nw++;
      if (o < exp_w && ow[o] !== 1'b0) early++;
    end
    checks++;
    if (ow[exp_w] !== 1'b1 || od[exp_w] !== 8'h41 || oa[exp_w] !== 32'h30000 || early != 0 || nw != 1) begin
      failures++;
      $display("FAIL io_stall_write got wr=%b dout=%h a=%h early=%0d writes=%0d exp write at %0d",
               ow[exp_w], od[exp_w], oa[exp_w], early, nw, exp_w);
    end
    checks++;
    if (done_off !== exp_w + 1) begin failures++; $display("FAIL io_stall_done got=%0d exp=%0d", done_off, exp_w + 1); end
    run_txn(2, 32'h20000, 3'd1, 32'h0000_0077, -1, -1, 0, 3);
    checks++;
    if (done_off !== 2 || ow[1] !== 1'b1) begin
      failures++; $display("FAIL io_nonio_store got done=%0d wr1=%b exp 2/1", done_off, ow[1]);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    lsb_write_signal = 1'b1; mem_addr = 32'h900; requiring_length = 3'd4; to_mem_data = $urandom;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b1) begin failures++; $display("FAIL rstmid_writing got wr=%b exp=1", mem_wr); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_dout !== 8'd0 || from_mem_data !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_async got wr=%b a=%h dout=%h lsbdata=%h exp 0", mem_wr, mem_a, mem_dout, from_mem_data);
    end
    lsb_write_signal = 1'b0;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (lsb_done === 1'b1 || if_done === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rstmid_nodone got=%0d exp=0", seen); end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; jump_wrong = 1'b0; io_buffer_full = 1'b0;
    if_read_signal = 1'b0; lsb_read_signal = 1'b0; lsb_write_signal = 1'b0;
    if_addr = 32'd0; mem_addr = 32'd0; requiring_length = 3'd0; to_mem_data = 32'd0;
    test_reset();
    test_fetch();
    test_random_reads();
    test_priority();
    test_store();
    test_flush();
    test_rdy();
    test_io_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
